bcd_countdown: RTL and testbench

Loadable 3-digit BCD countdown timer: the decrementing counterpart of the team's 3-digit BCD incrementor. It accepts a BCD value over a valid/ready load port and decrements it by one every PRESCALE enabled clock cycles, with digit-wise borrow. It stops at 000 and pulses `done`. It sits beside the incrementor in the BCD datapath and drives display and timeout logic directly with packed BCD.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_countdown.sv | 123 ++++++++++++
 tb/tb_bcd_countdown.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD datapath types, constants and helpers.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    CD_IDLE,
    CD_RUN,
    CD_EXPIRED
  } cd_state_e;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_digit_valid(bcd_digit_t d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained decrementer (purely combinational).
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  // Subtract the incoming borrow; 0 wraps to 9 and propagates the borrow.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = BCD_MAX_DIGIT;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD countdown timer with prescaler, done/err pulses.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_bcd,
  input  logic                  en,
  input  logic                  abort,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  cd_state_e             state_q, state_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [4*DIGITS-1:0]   dec_bcd;
  logic [DIGITS:0]       borrow;
  logic                  load_ok;
  logic                  load_fire;

  assign borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_digit_dec u_dec (
        .digit_in   (bcd_q[4*g +: 4]),
        .borrow_in  (borrow[g]),
        .digit_out  (dec_bcd[4*g +: 4]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // Every digit of the load value must be a decimal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(load_bcd[4*i +: 4])) load_ok = 1'b0;
    end
  end

  assign load_fire = load_valid && (state_q != CD_RUN);

  // Next-state: abort beats load beats count; done/err default low so they pulse.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == CD_RUN) begin
      if (abort) begin
        state_d = CD_IDLE;
        pre_d   = '0;
      end else if (en) begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          // A top-digit borrow cannot happen from a non-zero count; treat it as expiry anyway.
          if ((dec_bcd == '0) || borrow[DIGITS]) begin
            bcd_d   = '0;
            state_d = CD_EXPIRED;
            done_d  = 1'b1;
          end else begin
            bcd_d = dec_bcd;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end else if (!abort && load_fire) begin
      if (!load_ok) begin
        err_d = 1'b1;
      end else if (load_bcd == '0) begin
        bcd_d   = '0;
        state_d = CD_EXPIRED;
        done_d  = 1'b1;
      end else begin
        bcd_d   = load_bcd;
        pre_d   = '0;
        state_d = CD_RUN;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CD_IDLE;
      bcd_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign busy       = (state_q == CD_RUN);
  assign load_ready = (state_q != CD_RUN);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed scoreboard bench for bcd_countdown at PRESCALE=1 (dut a) and PRESCALE=4 (dut b).
module tb_bcd_countdown;

  typedef struct {
    string       tag;
    logic [11:0] bcd;
    logic        busy;
    logic        ready;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1, a_load_valid = 1'b0, a_en = 1'b0, a_abort = 1'b0;
  logic [11:0] a_load_bcd = '0;
  logic        a_load_ready, a_busy, a_done, a_err;
  logic [11:0] a_bcd_out;

  logic        b_reset = 1'b1, b_load_valid = 1'b0, b_en = 1'b0, b_abort = 1'b0;
  logic [11:0] b_load_bcd = '0;
  logic        b_load_ready, b_busy, b_done, b_err;
  logic [11:0] b_bcd_out;

  bcd_countdown #(.DIGITS(3), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(a_reset), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .load_bcd(a_load_bcd), .en(a_en), .abort(a_abort), .bcd_out(a_bcd_out),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  bcd_countdown #(.DIGITS(3), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(b_reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .load_bcd(b_load_bcd), .en(b_en), .abort(b_abort), .bcd_out(b_bcd_out),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [11:0] bcd, input logic busy,
                      input logic ready, input logic done, input logic err);
    exp_t e;
    e.tag = tag; e.bcd = bcd; e.busy = busy; e.ready = ready; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  // Advance one clock, then pop the oldest expectation and compare it against the chosen DUT.
  task automatic cycle(input bit use_b);
    exp_t        e;
    logic [11:0] ob;
    logic        obusy, oready, odone, oerr;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    if (use_b) begin
      ob = b_bcd_out; obusy = b_busy; oready = b_load_ready; odone = b_done; oerr = b_err;
    end else begin
      ob = a_bcd_out; obusy = a_busy; oready = a_load_ready; odone = a_done; oerr = a_err;
    end
    chk({e.tag, ".bcd"},   ob,            e.bcd);
    chk({e.tag, ".busy"},  12'(obusy),    12'(e.busy));
    chk({e.tag, ".ready"}, 12'(oready),   12'(e.ready));
    chk({e.tag, ".done"},  12'(odone),    12'(e.done));
    chk({e.tag, ".err"},   12'(oerr),     12'(e.err));
  endtask

  // Load a non-zero value into dut a (PRESCALE=1, en high) and follow it down to 000.
  task automatic count_a(input int v);
    a_load_valid = 1'b1;
    a_load_bcd   = to_bcd(v);
    a_en         = 1'b1;
    push("load", to_bcd(v), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0);
    a_load_valid = 1'b0;
    for (int k = 1; k <= v; k++) begin
      push("tick", to_bcd(v - k), k < v, k == v, k == v, 1'b0);
      cycle(0);
    end
    push("post_expire", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0);
  endtask

  logic [5:0] pat;
  int         c;

  initial begin
    // Reset state
    push("reset", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0);
    a_reset = 1'b0;

    // 100 down to 000, then borrow across digits from 010, then reload from EXPIRED
    count_a(100);
    count_a(10);
    count_a(1);

    // Abort after two ticks while a load is held pending
    a_load_valid = 1'b1; a_load_bcd = 12'h057; a_en = 1'b1;
    push("ab_load", 12'h057, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    push("ab_t1",   12'h056, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    push("ab_t2",   12'h055, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    a_abort = 1'b1;
    push("abort",   12'h055, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);
    a_abort = 1'b0;
    push("held",    12'h057, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    a_load_valid = 1'b0; a_abort = 1'b1;
    push("abort2",  12'h057, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);

    // Invalid load leaves count untouched and pulses err once
    a_abort = 1'b0; a_load_valid = 1'b1; a_load_bcd = 12'h0A5;
    push("bad",     12'h057, 1'b0, 1'b1, 1'b0, 1'b1); cycle(0);
    a_load_valid = 1'b0;
    push("bad_end", 12'h057, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);

    // Zero load expires on the accepting edge
    a_load_valid = 1'b1; a_load_bcd = 12'h000;
    push("zero",    12'h000, 1'b0, 1'b1, 1'b1, 1'b0); cycle(0);
    a_load_valid = 1'b0;
    push("zero_end",12'h000, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);

    // Reset mid-RUN beats load and abort
    a_load_valid = 1'b1; a_load_bcd = 12'h042; a_en = 1'b0;
    push("r_load",  12'h042, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    push("en_low",  12'h042, 1'b1, 1'b0, 1'b0, 1'b0); cycle(0);
    a_reset = 1'b1; a_abort = 1'b1; a_en = 1'b1;
    push("midreset",12'h000, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);
    a_reset = 1'b0; a_abort = 1'b0; a_load_valid = 1'b0;
    push("idle",    12'h000, 1'b0, 1'b1, 1'b0, 1'b0); cycle(0);
    count_a(2);

    // PRESCALE=4 with gated enable: decrement on every 4th enabled cycle
    push("b_reset", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0); cycle(1);
    b_reset = 1'b0;
    b_load_valid = 1'b1; b_load_bcd = 12'h003; b_en = 1'b0;
    push("b_load",  12'h003, 1'b1, 1'b0, 1'b0, 1'b0); cycle(1);
    b_load_valid = 1'b0;
    pat = 6'b101101;
    c   = 0;
    for (int i = 0; i < 40 && c < 12; i++) begin
      b_en = pat[i % 6];
      if (b_en) c++;
      push("b_tick", to_bcd(3 - c / 4), c != 12, c == 12, b_en && c == 12, 1'b0);
      cycle(1);
    end
    total++;
    assert (c == 12) pass_cnt++;
    else $error("FAIL b_budget: observed %0d enabled cycles expected 12", c);
    b_en = 1'b1;
    push("b_post",  12'h000, 1'b0, 1'b1, 1'b0, 1'b0); cycle(1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
